// File: rtl/decode_field_buffer.sv
// decode_field_buffer: decode-stage FIFO presenting its head instruction as RV32I fields and a sign-extended immediate
module decode_field_buffer #(
    parameter int XLEN  = 32,
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [4:0]      rd_addr,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);
    localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [31:0]     mem_instr [DEPTH];
    logic [PC_W-1:0] mem_pc    [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;
    logic [31:0]     ins, imm32;
    logic [2:0]      fmt_raw;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    assign in_ready  = !reset && count < CW'(DEPTH);
    assign out_valid = count != '0;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop) rd_ptr <= nxt(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_instr[wr_ptr] <= in_instr;
            mem_pc[wr_ptr]    <= in_pc;
        end
    end

    // An empty buffer decodes a zero word, so every field reads 0 and fmt falls to invalid
    assign ins      = out_valid ? mem_instr[rd_ptr] : '0;
    assign out_pc   = out_valid ? mem_pc[rd_ptr] : '0;
    assign opcode   = ins[6:0];
    assign rd_addr  = ins[11:7];
    assign funct3   = ins[14:12];
    assign rs1_addr = ins[19:15];
    assign rs2_addr = ins[24:20];
    assign funct7   = ins[31:25];

    always_comb begin
        fmt_raw = 3'd7;
        case (ins[6:0])
            7'b0110111, 7'b0010111: fmt_raw = 3'd4;
            7'b1101111: fmt_raw = 3'd5;
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: fmt_raw = 3'd1;
            7'b1100011: fmt_raw = 3'd3;
            7'b0100011: fmt_raw = 3'd2;
            7'b0110011: fmt_raw = 3'd0;
            default: fmt_raw = 3'd7;
        endcase
    end

    always_comb begin
        imm32 = fmt_raw == 3'd1 ? {{20{ins[31]}}, ins[31:20]} :
                fmt_raw == 3'd2 ? {{20{ins[31]}}, ins[31:25], ins[11:7]} :
                fmt_raw == 3'd3 ? {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0} :
                fmt_raw == 3'd4 ? {ins[31:12], 12'b0} :
                fmt_raw == 3'd5 ? {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0} :
                32'd0;
    end

    assign imm     = XLEN'(signed'(imm32));
    assign fmt     = out_valid ? fmt_raw : 3'd7;
    assign illegal = out_valid && (fmt_raw == 3'd7 || ins[1:0] != 2'b11);
endmodule

// File: tb/tb_decode_field_buffer.sv
// tb_decode_field_buffer: table vectors, directed corner sequences and randomized traffic against a queue model
module tb_decode_field_buffer;
    logic        clk = 0, reset = 1, flush = 0;
    logic        in_valid = 0, out_ready = 0, in_valid1 = 0, out_ready1 = 0;
    logic [31:0] in_instr = 0, in_pc = 0;

    logic        in_ready, out_valid, illegal;
    logic [31:0] out_pc, imm;
    logic [6:0]  opcode, funct7;
    logic [4:0]  rd_addr, rs1_addr, rs2_addr;
    logic [2:0]  funct3, fmt;

    logic        w_in_ready, w_out_valid, w_illegal;
    logic [31:0] w_out_pc;
    logic [63:0] w_imm;
    logic [6:0]  w_opcode, w_funct7;
    logic [4:0]  w_rd, w_rs1, w_rs2;
    logic [2:0]  w_funct3, w_fmt;

    logic        s_in_ready, s_out_valid, s_illegal;
    logic [31:0] s_out_pc, s_imm;
    logic [6:0]  s_opcode, s_funct7;
    logic [4:0]  s_rd, s_rs1, s_rs2;
    logic [2:0]  s_funct3, s_fmt;

    int          n_cmp = 0, n_bad = 0;
    logic [63:0] q[$], q1[$];

    always #5 clk = ~clk;

    decode_field_buffer dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .opcode(opcode), .rd_addr(rd_addr), .rs1_addr(rs1_addr),
        .rs2_addr(rs2_addr), .funct3(funct3), .funct7(funct7), .imm(imm), .fmt(fmt),
        .illegal(illegal)
    );

    decode_field_buffer #(.XLEN(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(w_out_valid), .out_ready(out_ready),
        .out_pc(w_out_pc), .opcode(w_opcode), .rd_addr(w_rd), .rs1_addr(w_rs1),
        .rs2_addr(w_rs2), .funct3(w_funct3), .funct7(w_funct7), .imm(w_imm), .fmt(w_fmt),
        .illegal(w_illegal)
    );

    decode_field_buffer #(.DEPTH(1)) dut1 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid1), .in_ready(s_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(s_out_valid), .out_ready(out_ready1),
        .out_pc(s_out_pc), .opcode(s_opcode), .rd_addr(s_rd), .rs1_addr(s_rs1),
        .rs2_addr(s_rs2), .funct3(s_funct3), .funct7(s_funct7), .imm(s_imm), .fmt(s_fmt),
        .illegal(s_illegal)
    );

    // Reference decode: format from the opcode table, immediate assembled to 64 bits
    function automatic void dec(input logic [31:0] i, output logic [2:0] f, output logic [63:0] m);
        f = 3'd7;
        m = '0;
        case (i[6:0])
            7'b0110111, 7'b0010111: begin f = 3'd4; m = {{32{i[31]}}, i[31:12], 12'b0}; end
            7'b1101111: begin f = 3'd5; m = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011:
                begin f = 3'd1; m = {{52{i[31]}}, i[31:20]}; end
            7'b1100011: begin f = 3'd3; m = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
            7'b0100011: begin f = 3'd2; m = {{52{i[31]}}, i[31:25], i[11:7]}; end
            7'b0110011: f = 3'd0;
            default: ;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic check_all;
        logic [63:0] h, m, m1, h1;
        logic [2:0]  f, f1;
        logic        v, v1;
        v  = q.size() != 0;
        h  = v ? q[0] : 64'd0;
        dec(h[31:0], f, m);
        chk("in_ready", in_ready, !reset && q.size() < 2);
        chk("out_valid", out_valid, v);
        chk("out_pc", out_pc, h[63:32]);
        chk("opcode", opcode, h[6:0]);
        chk("rd_addr", rd_addr, h[11:7]);
        chk("rs1_addr", rs1_addr, h[19:15]);
        chk("rs2_addr", rs2_addr, h[24:20]);
        chk("funct3", funct3, h[14:12]);
        chk("funct7", funct7, h[31:25]);
        chk("imm", imm, m[31:0]);
        chk("fmt", fmt, f);
        chk("illegal", illegal, v && (f == 3'd7 || h[1:0] != 2'b11));
        chk("x64_imm", w_imm, m);
        chk("x64_valid", w_out_valid, v);
        v1 = q1.size() != 0;
        h1 = v1 ? q1[0] : 64'd0;
        dec(h1[31:0], f1, m1);
        chk("d1_in_ready", s_in_ready, !reset && q1.size() < 1);
        chk("d1_out_valid", s_out_valid, v1);
        chk("d1_out_pc", s_out_pc, h1[63:32]);
        chk("d1_imm", s_imm, m1[31:0]);
        chk("d1_fmt", s_fmt, f1);
    endtask

    task automatic tick;
        logic p, pp, p1, pp1;
        @(posedge clk);
        p   = in_valid && !reset && q.size() < 2;
        pp  = q.size() != 0 && out_ready;
        p1  = in_valid1 && !reset && q1.size() < 1;
        pp1 = q1.size() != 0 && out_ready1;
        if (reset || flush) begin
            q.delete();
            q1.delete();
        end else begin
            if (pp) void'(q.pop_front());
            if (p) q.push_back({in_pc, in_instr});
            if (pp1) void'(q1.pop_front());
            if (p1) q1.push_back({in_pc, in_instr});
        end
        #1;
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h13, 7'h0F, 7'h73, 7'h63, 7'h23, 7'h33};
        logic [31:0] r;
        r = $urandom;
        return $urandom_range(0, 9) < 8 ? {r[31:7], ops[$urandom_range(0, 10)]} : r;
    endfunction

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  f;
        logic [63:0] m;
        logic        il;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
    } vec_t;

    vec_t        tv [9];
    logic [31:0] got[$];
    int          nacc;
    logic        acc;

    initial begin
        tv[0] = '{32'hFFF10093, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 5'd1, 5'd2, 5'd31, 3'd0};
        tv[1] = '{32'h00532423, 3'd2, 64'h8, 1'b0, 5'd8, 5'd6, 5'd5, 3'd2};
        tv[2] = '{32'hFE000EE3, 3'd3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0, 5'd29, 5'd0, 5'd0, 3'd0};
        tv[3] = '{32'h123451B7, 3'd4, 64'h1234_5000, 1'b0, 5'd3, 5'd8, 5'd3, 3'd5};
        tv[4] = '{32'h00000000, 3'd7, 64'h0, 1'b1, 5'd0, 5'd0, 5'd0, 3'd0};
        tv[5] = '{32'h00000013, 3'd1, 64'h0, 1'b0, 5'd0, 5'd0, 5'd0, 3'd0};
        tv[6] = '{32'h008000EF, 3'd5, 64'h8, 1'b0, 5'd1, 5'd0, 5'd8, 3'd0};
        tv[7] = '{32'h002081B3, 3'd0, 64'h0, 1'b0, 5'd3, 5'd1, 5'd2, 3'd0};
        tv[8] = '{32'h00000012, 3'd7, 64'h0, 1'b1, 5'd0, 5'd0, 5'd0, 3'd0};

        tick(); tick();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_fmt", fmt, 3'd7);
        reset = 0;
        tick();
        chk("post_rst_in_ready", in_ready, 1);

        for (int k = 0; k < 9; k++) begin
            in_valid = 1; in_instr = tv[k].instr; in_pc = 32'h100 + 32'(4 * k); out_ready = 1;
            tick();
            in_valid = 0;
            chk("tv_valid", out_valid, 1);
            chk("tv_pc", out_pc, 32'h100 + 32'(4 * k));
            chk("tv_fmt", fmt, tv[k].f);
            chk("tv_imm", imm, tv[k].m[31:0]);
            chk("tv_imm64", w_imm, tv[k].m);
            chk("tv_illegal", illegal, tv[k].il);
            chk("tv_rd", rd_addr, tv[k].rd);
            chk("tv_rs1", rs1_addr, tv[k].rs1);
            chk("tv_rs2", rs2_addr, tv[k].rs2);
            chk("tv_funct3", funct3, tv[k].f3);
            tick();
        end

        out_ready = 0; in_valid = 1;
        in_instr = 32'h00000013; in_pc = 32'h200; tick();
        in_instr = 32'h00532423; in_pc = 32'h204; tick();
        chk("bp_full", in_ready, 0);
        in_instr = 32'h123451B7; in_pc = 32'h208; tick();
        chk("bp_hold", in_ready, 0);
        chk("bp_head", out_pc, 32'h200);
        out_ready = 1;
        for (int c = 0; c < 12; c++) begin
            acc = in_valid && in_ready;
            if (out_valid) got.push_back(out_pc);
            tick();
            if (acc) in_valid = 0;
        end
        chk("bp_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("bp_order", got[i], 32'h200 + 32'(4 * i));

        in_valid1 = 1; out_ready1 = 1; nacc = 0;
        for (int c = 0; c < 8; c++) begin
            if (in_valid1 && s_in_ready) nacc++;
            in_instr = 32'h00000013 + (32'(c) << 7); in_pc = 32'h300 + 32'(4 * c);
            tick();
        end
        chk("d1_rate", nacc, 4);
        in_valid1 = 0;
        tick(); tick();

        out_ready = 0; in_valid = 1;
        in_instr = 32'h00100093; in_pc = 32'h400; tick();
        in_instr = 32'h00200093; in_pc = 32'h404; tick();
        chk("fl_full", in_ready, 0);
        flush = 1; in_instr = 32'h00300093; in_pc = 32'h408; tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        flush = 0; in_instr = 32'h00400093; in_pc = 32'h40C; tick();
        flush = 1; in_instr = 32'h00500093; in_pc = 32'h410; tick();
        flush = 0; in_valid = 0; tick();
        chk("fl_drop", out_valid, 0);

        in_valid = 1; in_instr = 32'h00600093; in_pc = 32'h500; tick();
        reset = 1; tick();
        chk("mr_in_ready", in_ready, 0);
        chk("mr_out_valid", out_valid, 0);
        tick();
        reset = 0; in_valid = 0; tick();
        chk("mr_empty", out_valid, 0);
        chk("mr_in_ready_after", in_ready, 1);

        for (int c = 0; c < 3000; c++) begin
            in_valid   = $urandom_range(0, 3) != 0;
            out_ready  = $urandom_range(0, 2) != 0;
            in_valid1  = $urandom_range(0, 1) != 0;
            out_ready1 = $urandom_range(0, 2) != 0;
            flush      = $urandom_range(0, 40) == 0;
            reset      = $urandom_range(0, 200) == 0;
            in_instr   = rand_instr();
            in_pc      = $urandom;
            tick();
        end
        reset = 0; flush = 0; in_valid = 0; in_valid1 = 0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
